// File: rtl/stream_fifo.sv
// stream_fifo -- first-word-fall-through stream FIFO with valid/ready ports.
//
// Handshake: a push happens on a rising clk edge where s_valid && s_ready;
// a pop happens on a rising clk edge where m_valid && m_ready. s_ready,
// m_valid, fill_level, almost_full and almost_empty are registers computed
// from the next-state fill, so no input reaches an output combinationally.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset (wins over all)
//   flush             synchronous clear of pointers/fill (wins over handshakes)
//   s_valid/s_ready/s_data   write side
//   m_valid/m_ready/m_data   read side, m_data shows the word at the read cursor
//   fill_level        number of stored words
//   almost_full       free slots <= ALMOST_FULL_FREE
//   almost_empty      fill_level <= ALMOST_EMPTY_FILL
//   circular, m_wrap  replay mode request / wrap pulse
//
// Optional feature: define STREAM_FIFO_CIRCULAR_EN to build replay mode. In
// the default build circular is ignored and m_wrap is constant 0.
module stream_fifo #(
  parameter int WIDTH             = 32,
  parameter int DEPTH             = 32,
  parameter int ALMOST_FULL_FREE  = 1,
  parameter int ALMOST_EMPTY_FILL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic                       almost_full,
  output logic                       almost_empty,
  input  logic                       circular,
  output logic                       m_wrap
);

  localparam int FW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage is never cleared; only pointers and flags are.
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;     // read cursor, drives m_data
  logic [FW-1:0] r_fill;
  logic          r_s_ready;
  logic          r_m_valid;
  logic          r_almost_full;
  logic          r_almost_empty;
  logic          r_wrap;

  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_wr_next;
  logic [PW-1:0] w_rd_next;
  logic [FW-1:0] w_fill_next;
  logic          w_wrap_next;

  // Modulo-DEPTH increment, correct for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

`ifdef STREAM_FIFO_CIRCULAR_EN
  // Oldest stored word; differs from the read cursor only while replaying.
  logic [PW-1:0] r_head;
  logic [PW-1:0] w_head_next;
`else
  logic w_unused_circular;
  assign w_unused_circular = circular;
`endif

  always_comb begin
    w_push      = s_valid && r_s_ready;
    w_pop       = r_m_valid && m_ready;
    w_wr_next   = r_wr_ptr;
    w_rd_next   = r_rd_ptr;
    w_fill_next = r_fill;
    w_wrap_next = 1'b0;
`ifdef STREAM_FIFO_CIRCULAR_EN
    w_head_next = r_head;
`endif
    if (reset || flush) begin
      w_wr_next   = '0;
      w_rd_next   = '0;
      w_fill_next = '0;
`ifdef STREAM_FIFO_CIRCULAR_EN
      w_head_next = '0;
`endif
    end else begin
      if (w_push) w_wr_next = ptr_inc(r_wr_ptr);
`ifdef STREAM_FIFO_CIRCULAR_EN
      if (circular) begin
        // Replay: the cursor walks the stored words without freeing them and
        // jumps back to the oldest word after the newest one is read.
        if (w_pop) begin
          if (ptr_inc(r_rd_ptr) == r_wr_ptr) begin
            w_rd_next   = r_head;
            w_wrap_next = 1'b1;
          end else begin
            w_rd_next = ptr_inc(r_rd_ptr);
          end
        end
        w_fill_next = r_fill + FW'(w_push);
      end else begin
        // Normal draining; the cursor snaps back to the oldest word.
        if (w_pop) w_head_next = ptr_inc(r_head);
        w_rd_next   = w_head_next;
        w_fill_next = r_fill + FW'(w_push) - FW'(w_pop);
      end
`else
      if (w_pop) w_rd_next = ptr_inc(r_rd_ptr);
      w_fill_next = r_fill + FW'(w_push) - FW'(w_pop);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset && !flush) r_mem[r_wr_ptr] <= s_data;
  end

  // Reset and flush are folded into the next-state values above, so the
  // flags take their cleared values from the same expressions.
  always_ff @(posedge clk) begin
    r_wr_ptr       <= w_wr_next;
    r_rd_ptr       <= w_rd_next;
    r_fill         <= w_fill_next;
    r_s_ready      <= (32'(w_fill_next) != DEPTH);
    r_m_valid      <= (w_fill_next != '0);
    r_almost_full  <= ((DEPTH - 32'(w_fill_next)) <= ALMOST_FULL_FREE);
    r_almost_empty <= (32'(w_fill_next) <= ALMOST_EMPTY_FILL);
    r_wrap         <= reset ? 1'b0 : w_wrap_next;
`ifdef STREAM_FIFO_CIRCULAR_EN
    r_head         <= w_head_next;
`endif
  end

  assign s_ready      = r_s_ready;
  assign m_valid      = r_m_valid;
  assign m_data       = r_mem[r_rd_ptr];
  assign fill_level   = r_fill;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
`ifdef STREAM_FIFO_CIRCULAR_EN
  assign m_wrap       = r_wrap;
`else
  assign m_wrap       = 1'b0;
`endif

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits (1..1024).
REQ-002 SHALL have parameter DEPTH, default 32, capacity in words (1..65536); any integer is legal, not only a power of two.
REQ-003 SHALL have parameter ALMOST_FULL_FREE, default 1: almost_full is asserted when free slots <= this value.
REQ-004 SHALL have parameter ALMOST_EMPTY_FILL, default 1: almost_empty is asserted when fill_level <= this value.
REQ-005 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1; reset is synchronous, active-high; clock is clk.
REQ-007 SHALL have port flush, input, 1, synchronous clear of contents without reset.
REQ-008 SHALL have port s_valid, input, 1, write request.
REQ-009 SHALL have port s_ready, output, 1, space available.
REQ-010 SHALL have port s_data, input, WIDTH, write data.
REQ-011 SHALL have port m_valid, output, 1, read data available.
REQ-012 SHALL have port m_ready, input, 1, consumer accepts.
REQ-013 SHALL have port m_data, output, WIDTH, first-word-fall-through read data.
REQ-014 SHALL have port fill_level, output, clog2(DEPTH+1), number of stored words.
REQ-015 SHALL have ports almost_full and almost_empty, output, 1 each, registered flags.
REQ-016 SHALL have port circular, input, 1, replay-mode request; ignored unless STREAM_FIFO_CIRCULAR_EN is defined.
REQ-017 SHALL have port m_wrap, output, 1, one-cycle pulse on the replay wrap.

Function
REQ-018 A push SHALL occur exactly when s_valid && s_ready at the clock edge; a pop SHALL occur exactly when m_valid && m_ready at the clock edge.
REQ-019 s_ready, m_valid, fill_level, almost_full and almost_empty SHALL be registered outputs computed from next-state fill, with no combinational path from any input.
REQ-020 s_ready SHALL equal (fill_level != DEPTH); m_valid SHALL equal (fill_level != 0).
REQ-021 A push into an empty FIFO at edge N SHALL give m_valid=1, with m_data equal to that word, from edge N+1 (latency 1).
REQ-022 m_data SHALL always present the word at the read cursor; its value is don't-care while m_valid=0.
REQ-023 A simultaneous push and pop SHALL leave fill_level unchanged and preserve word order; this includes fill_level==1.
REQ-024 When full, s_ready=0, so a pop in that cycle SHALL raise s_ready at the next edge; the FIFO SHALL NOT accept a write in the same cycle it frees a slot.
REQ-025 Write and read pointers SHALL advance modulo DEPTH: after index DEPTH-1 they return to 0, for non-power-of-two DEPTH as well.
REQ-026 flush SHALL set fill_level=0, pointers=0, m_valid=0 and s_ready=1 at the next edge, with priority over a push and a pop in the same cycle.
REQ-027 Storage contents SHALL NOT be cleared by flush or reset; only the pointers and flags are cleared.
REQ-028 Words SHALL be output in exact FIFO order with no loss or duplication (outside circular mode).

Reset
REQ-029 On reset, fill_level, pointers, m_valid and m_wrap SHALL be 0; s_ready SHALL be 1; almost_empty SHALL be 1; almost_full SHALL be (DEPTH <= ALMOST_FULL_FREE).
REQ-030 reset SHALL have priority over flush and over all handshakes; reset asserted mid-transfer SHALL discard all stored words.
REQ-031 After reset deasserts, the first push SHALL be accepted in the first cycle.

Configuration
REQ-032 Macro STREAM_FIFO_CIRCULAR_EN SHALL compile in replay mode; without it, circular is ignored, m_wrap is tied to 0 and no replay logic is present.
REQ-033 With the macro and circular=1, a pop SHALL advance the read cursor but SHALL NOT decrement fill_level or free the entry.
REQ-034 In that mode, a pop of the newest word (cursor at write pointer minus 1) SHALL return the cursor to the oldest word and pulse m_wrap for one cycle.
REQ-035 Pushes SHALL remain legal during replay and SHALL append after the newest word.
REQ-036 Deasserting circular SHALL return the cursor to the oldest word at the next edge; normal draining then resumes from the oldest word.

Verification
REQ-037 Scenario: DEPTH=5; push 0x1..0x5 -> s_ready=0 after the 5th push; pop 5 -> m_data sequence 1,2,3,4,5, then m_valid=0.
REQ-038 Scenario: DEPTH=5; run 12 push/pop pairs -> pointer wrap 4->0 is seen twice, fill_level stays at 1, and data order is intact.
REQ-039 Scenario: DEPTH=4, full; assert m_ready and s_valid in the same cycle -> one pop only; s_ready=1 in the next cycle; the next push is accepted.
REQ-040 Scenario: 3 words stored, flush together with s_valid=1 -> fill_level=0, m_valid=0, almost_empty=1; the pushed word is dropped.
REQ-041 Scenario: push 0xA at edge N into an empty FIFO -> m_valid=1 and m_data=0xA at N+1; assert reset at N+1 -> m_valid=0 at N+2.
REQ-042 Scenario (with STREAM_FIFO_CIRCULAR_EN): store A,B,C, circular=1, pop 7 times -> A,B,C,A,B,C,A; m_wrap pulses after each C; fill_level stays at 3.
